sync_mem_array: RTL and testbench

//   Single-port, synchronous, byte-wide RAM with one shared read/write strobe.

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_clear_ctrl.sv | 48 ++++
 rtl/sync_mem_array.sv | 92 +++++++++
 tb/tb_sync_mem_array.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and default sizes for the sync_mem_array slice
//
// Purpose : default geometry of the byte-wide RAM and the clear FSM state type.
// Contents: MEM_ADDR_W, MEM_DATA_W, DEPTH, mem_state_t.

package mem_pkg;

   localparam int MEM_ADDR_W = 8;
   localparam int MEM_DATA_W = 8;
   localparam int DEPTH      = 2 ** MEM_ADDR_W;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } mem_state_t;

endpackage

// File: rtl/mem_clear_ctrl.sv
// rtl/mem_clear_ctrl.sv - post-reset clear FSM and clear pointer
//
// Purpose : after reset, sweeps every word address once (one per clock) so the
//           top can write zero there, then parks in READY until the next reset.
// Ports   : i_clock     system clock
//           i_reset     synchronous active-high reset
//           o_busy      1 while the clear sweep is running
//           o_clr_we    clear write strobe for the array write port
//           o_clr_addr  address being cleared this cycle

module mem_clear_ctrl
   import mem_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W
) (
   input  logic              i_clock,
   input  logic              i_reset,
   output logic              o_busy,
   output logic              o_clr_we,
   output logic [ADDR_W-1:0] o_clr_addr
);

   mem_state_t        r_state;
   logic [ADDR_W-1:0] r_ptr;
   logic              r_busy;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= CLEAR;
         r_ptr   <= '0;
         r_busy  <= 1'b1;
      end else begin
         if (r_state == CLEAR) begin
            // ptr rolls back to 0 on the same edge the sweep finishes
            r_ptr <= r_ptr + 1'b1;
            if (r_ptr == '1) begin
               r_state <= READY;
               r_busy  <= 1'b0;
            end
         end
      end
   end

   assign o_busy     = r_busy;
   assign o_clr_we   = (r_state == CLEAR);
   assign o_clr_addr = r_ptr;

endmodule

// File: rtl/sync_mem_array.sv
// rtl/sync_mem_array.sv - single-port synchronous RAM with self-clear after reset
//
// Purpose : 2**ADDR_W x DATA_W RAM, one shared read/write strobe, registered
//           read data with one cycle latency, zero-filled after every reset.
// Ports   : clock       system clock
//           reset       synchronous active-high reset
//           address     word address of the access
//           data_in     write data
//           data_out    registered read data, 0 when no read is returned
//           read_write  1 = write, 0 = read (qualified by chip_en)
//           chip_en     access enable
//           busy        1 while the post-reset clear runs; accesses ignored

module sync_mem_array
   import mem_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   input  logic              read_write,
   input  logic              chip_en,
   output logic              busy
);

   localparam int ARR_DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [ARR_DEPTH];
   logic [DATA_W-1:0] r_data_out;

   logic              w_busy;
   logic              w_clr_we;
   logic [ADDR_W-1:0] w_clr_addr;
   logic              w_we;
   logic              w_rd;
   logic [ADDR_W-1:0] w_waddr;
   logic [DATA_W-1:0] w_wdata;

   mem_clear_ctrl #(
      .ADDR_W (ADDR_W)
   ) u_clear_ctrl (
      .i_clock    (clock),
      .i_reset    (reset),
      .o_busy     (w_busy),
      .o_clr_we   (w_clr_we),
      .o_clr_addr (w_clr_addr)
   );

   // Single array write port: the clear sweep owns it while busy, the user
   // port afterwards. Reset blocks every write, so an in-flight user write
   // at the reset edge is dropped.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = '0;
      w_wdata = '0;
      if (w_busy) begin
         w_we    = w_clr_we & ~reset;
         w_waddr = w_clr_addr;
      end else begin
         w_we    = chip_en & read_write & ~reset;
         w_waddr = address;
         w_wdata = data_in;
      end
   end

   assign w_rd = ~w_busy & chip_en & ~read_write;

   // No reset on the array so it maps onto block RAM.
   always_ff @(posedge clock) begin
      if (w_we) begin
         r_mem[w_waddr] <= w_wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_data_out <= '0;
      end else if (w_rd) begin
         r_data_out <= r_mem[address];
      end else begin
         r_data_out <= '0;
      end
   end

   assign data_out = r_data_out;
   assign busy     = w_busy;

endmodule

// File: tb/tb_sync_mem_array.sv
// tb/tb_sync_mem_array.sv - self-checking bench for sync_mem_array

module tb_sync_mem_array;

   logic       clock;
   logic       reset;
   logic [7:0] address;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       read_write;
   logic       chip_en;
   logic       busy;

   logic [7:0] model [256];
   int         n_checks;
   int         n_pass;

   sync_mem_array dut (
      .clock      (clock),
      .reset      (reset),
      .address    (address),
      .data_in    (data_in),
      .data_out   (data_out),
      .read_write (read_write),
      .chip_en    (chip_en),
      .busy       (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      chip_en    = 1'b0;
      read_write = 1'b0;
      address    = 8'h00;
      data_in    = 8'h00;
   endtask

   // Counts cycles until busy drops. With noise=1, random write attempts are
   // driven during the clear and must be ignored.
   task automatic wait_clear(input string tag, input int noise);
      int cnt;
      int dout_bad;
      cnt      = 0;
      dout_bad = 0;
      while (busy && cnt < 400) begin
         if (noise != 0) begin
            chip_en    = 1'b1;
            read_write = 1'($urandom_range(0, 1));
            address    = 8'($urandom);
            data_in    = 8'($urandom_range(1, 255));
         end
         cycle();
         cnt++;
         if (data_out !== 8'h00) dout_bad++;
      end
      idle();
      check({tag, "_busy_cycles"}, cnt, 256);
      check({tag, "_dout_zero_during_clear"}, dout_bad, 0);
      for (int i = 0; i < 256; i++) model[i] = 8'h00;
   endtask

   task automatic do_write(input string tag, input logic [7:0] a, input logic [7:0] d);
      chip_en = 1'b1; read_write = 1'b1; address = a; data_in = d;
      cycle();
      model[a] = d;
      idle();
      check(tag, data_out, 8'h00);
   endtask

   task automatic do_read(input string tag, input logic [7:0] a);
      chip_en = 1'b1; read_write = 1'b0; address = a; data_in = 8'($urandom);
      cycle();
      idle();
      check(tag, data_out, model[a]);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      idle();

      // 1: reset pulse, then idle through the clear
      reset = 1'b1;
      cycle();
      check("rst_busy", busy, 1);
      check("rst_dout", data_out, 0);
      reset = 1'b0;
      wait_clear("t1", 0);
      check("t1_busy_low", busy, 0);

      // 2: cleared contents
      do_read("t2_rd_00", 8'h00);
      do_read("t2_rd_7f", 8'h7F);
      do_read("t2_rd_ff", 8'hFF);

      // 3: writes then reads, including the top address
      do_write("t3_wr_10", 8'h10, 8'hA5);
      do_write("t3_wr_ff", 8'hFF, 8'h3C);
      do_read("t3_rd_10", 8'h10);
      check("t3_model_10", model[8'h10], 8'hA5);
      do_read("t3_rd_ff", 8'hFF);
      check("t3_model_ff", model[8'hFF], 8'h3C);

      // 4: disabled write must not land
      chip_en = 1'b0; read_write = 1'b1; address = 8'h20; data_in = 8'h55;
      cycle();
      check("t4_dout_ce0", data_out, 0);
      chip_en = 1'b0; read_write = 1'b0; address = 8'h20; data_in = 8'h77;
      cycle();
      check("t4_dout_ce0_rd", data_out, 0);
      do_read("t4_rd_20", 8'h20);

      // back-to-back write then read of the same address
      chip_en = 1'b1; read_write = 1'b1; address = 8'h33; data_in = 8'h9E;
      cycle();
      check("b2b_wr_dout", data_out, 0);
      model[8'h33] = 8'h9E;
      read_write = 1'b0;
      cycle();
      check("b2b_rd", data_out, 8'h9E);
      idle();

      // 5: write, reset (with an in-flight write), reset again mid-clear
      do_write("t5_wr_05", 8'h05, 8'h11);
      reset = 1'b1;
      chip_en = 1'b1; read_write = 1'b1; address = 8'h06; data_in = 8'hEE;
      cycle();
      idle();
      reset = 1'b0;
      for (int i = 0; i < 100; i++) begin
         chip_en = 1'b1; read_write = 1'b1; address = 8'h05; data_in = 8'h42;
         cycle();
      end
      check("t5_busy_mid", busy, 1);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      check("t5_busy_rst2", busy, 1);
      wait_clear("t5", 1);
      do_read("t5_rd_05", 8'h05);
      do_read("t5_rd_06", 8'h06);

      // 6: random stream against the array model
      for (int i = 0; i < 1200; i++) begin
         logic       ce, rw;
         logic [7:0] a, d, exp;
         ce  = ($urandom_range(0, 9) != 0);
         rw  = 1'($urandom_range(0, 1));
         a   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
         d   = 8'($urandom);
         chip_en = ce; read_write = rw; address = a; data_in = d;
         exp = (ce && !rw) ? model[a] : 8'h00;
         cycle();
         if (ce && rw) model[a] = d;
         check("t6_rand", data_out, exp);
      end
      idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
